mc_control: RTL and testbench
=============================

MC_CONTROL -- requirements
Module: mc_control

Interface
REQ-001 SHALL have parameter OP_W, default 6, opcode field width.
REQ-002 SHALL have parameter CNT_W, default 32, retired-instruction counter width.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port opcode, input, OP_W, instruction[31:26] from the instruction register.
REQ-006 SHALL have port zero, input, 1, ALU zero flag.
REQ-007 SHALL have port mem_ready, input, 1, memory access complete.
REQ-008 SHALL have the following outputs, 1 bit each:
- pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write
- mem_to_reg, reg_dst, reg_write, alu_src_a, illegal_op
REQ-009 SHALL have outputs alu_src_b, alu_op and pc_source, 2 bits each.
REQ-010 SHALL have outputs state, 4 bits, current FSM state; and instr_count, CNT_W bits, retired instructions.

Function
REQ-011 SHALL be a Moore FSM; all control outputs SHALL decode from registered state only, except pc_write_cond (gated externally with zero) and illegal_op.
REQ-012 SHALL use these states and encodings:
- IDLE=0, FETCH=1, DECODE=2, MEM_ADDR=3
- MEM_RD=4, MEM_WB=5, MEM_WR=6, EXEC=7
- R_WB=8, BRANCH=9, JUMP=10, ADDI_EX=11, ADDI_WB=12
REQ-013 alu_src_b encoding SHALL be: 00 regB, 01 constant 4, 10 sign-extended immediate, 11 sign-extended immediate shifted left 2.
REQ-014 pc_source encoding SHALL be: 00 ALU result, 01 ALUOut, 10 jump target {PC[31:28], instr[25:0], 00}.
REQ-015 alu_op encoding SHALL be: 00 add, 01 subtract, 10 funct-decoded.
REQ-016 IDLE: all outputs 0; next state FETCH unconditionally.
REQ-017 FETCH: mem_read=1, ir_write=1, alu_src_a=0, alu_src_b=01, alu_op=00, pc_write=1, pc_source=00; next state DECODE.
REQ-018 DECODE: alu_src_a=0, alu_src_b=11, alu_op=00 (branch target into ALUOut).
REQ-019 DECODE next state by opcode:
- 0x00 -> EXEC; 0x23 or 0x2B -> MEM_ADDR; 0x04 -> BRANCH
- 0x02 -> JUMP; 0x08 -> ADDI_EX
REQ-020 Any other opcode in DECODE SHALL pulse illegal_op for that one cycle, go to FETCH, and not increment instr_count.
REQ-021 MEM_ADDR and ADDI_EX: alu_src_a=1, alu_src_b=10, alu_op=00. MEM_ADDR goes to MEM_RD on 0x23, MEM_WR on 0x2B; ADDI_EX goes to ADDI_WB.
REQ-022 MEM_RD: mem_read=1, i_or_d=1; next MEM_WB. MEM_WB: reg_write=1, mem_to_reg=1, reg_dst=0.
REQ-023 MEM_WR: mem_write=1, i_or_d=1.
REQ-024 EXEC: alu_src_a=1, alu_src_b=00, alu_op=10; next R_WB. R_WB: reg_write=1, reg_dst=1, mem_to_reg=0.
REQ-025 ADDI_WB: reg_write=1, reg_dst=0, mem_to_reg=0.
REQ-026 BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01.
REQ-027 JUMP: pc_write=1, pc_source=10.
REQ-028 MEM_WB, MEM_WR, R_WB, ADDI_WB, BRANCH and JUMP SHALL return to FETCH.
REQ-029 instr_count SHALL increment by 1 on each transition from those six states to FETCH, wrapping modulo 2^CNT_W.
REQ-030 Unreachable state encodings (13-15) SHALL go to IDLE next cycle with all outputs 0.
REQ-031 Instruction latency without wait states SHALL be: R-type/addi 4, lw 5, sw 4, beq 3, j 3 cycles.

Reset
REQ-032 rst_n low SHALL immediately force state=IDLE and instr_count=0, which makes every control output 0, regardless of clk.
REQ-033 Reset asserted mid-instruction SHALL abandon it without counting; after release, the first rising edge goes to FETCH.

Configuration
REQ-034 With MEM_HANDSHAKE_EN defined, FETCH, MEM_RD and MEM_WR SHALL hold state and outputs until mem_ready=1 at a rising edge; pc_write in FETCH SHALL be asserted only when mem_ready=1.
REQ-035 Without MEM_HANDSHAKE_EN, mem_ready SHALL be ignored and those states SHALL last exactly one cycle.

Structure
REQ-036 State encodings, opcode constants and alu_op/alu_src_b/pc_source encodings SHALL live in shared package mc_ctrl_pkg.
REQ-037 Output decode SHALL be one combinational sub-module mc_ctrl_decode (state in, control outputs out); the next-state logic and counter SHALL stay in mc_control.

Verification
REQ-038 Reset held, then released; opcode=0x00 -> states IDLE, FETCH, DECODE, EXEC, R_WB, FETCH; instr_count=1; reg_dst=1 in R_WB.
REQ-039 opcode=0x23 -> MEM_ADDR, MEM_RD, MEM_WB; i_or_d=1 in MEM_RD; mem_to_reg=1 in MEM_WB.
REQ-040 opcode=0x04 with zero=1, then zero=0 -> pc_write_cond=1, pc_source=01, alu_op=01 in BRANCH; 3 cycles each; count +2.
REQ-041 opcode=0x3F -> illegal_op=1 for one cycle in DECODE, then FETCH; instr_count unchanged.
REQ-042 With MEM_HANDSHAKE_EN, mem_ready=0 for 3 cycles in FETCH -> state held 4 cycles, pc_write=0 until mem_ready=1.
REQ-043 rst_n dropped mid MEM_WR -> state=IDLE, mem_write=0 and instr_count=0 immediately, before the next clk edge.

Source files
------------

// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multicycle CPU controller: FSM states, opcodes,
// datapath mux selects and the bundled control word driven by the decoder.
package mc_ctrl_pkg;

  localparam int STATE_W = 4;

  localparam logic [3:0] S_IDLE     = 4'd0;
  localparam logic [3:0] S_FETCH    = 4'd1;
  localparam logic [3:0] S_DECODE   = 4'd2;
  localparam logic [3:0] S_MEM_ADDR = 4'd3;
  localparam logic [3:0] S_MEM_RD   = 4'd4;
  localparam logic [3:0] S_MEM_WB   = 4'd5;
  localparam logic [3:0] S_MEM_WR   = 4'd6;
  localparam logic [3:0] S_EXEC     = 4'd7;
  localparam logic [3:0] S_R_WB     = 4'd8;
  localparam logic [3:0] S_BRANCH   = 4'd9;
  localparam logic [3:0] S_JUMP     = 4'd10;
  localparam logic [3:0] S_ADDI_EX  = 4'd11;
  localparam logic [3:0] S_ADDI_WB  = 4'd12;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_REGB    = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
  } ctrl_t;

  localparam ctrl_t CTRL_NONE = '0;

  // States whose exit to FETCH completes (retires) an instruction.
  function automatic logic is_retire_state(input logic [3:0] s);
    return (s == S_MEM_WB) || (s == S_MEM_WR) || (s == S_R_WB) ||
           (s == S_ADDI_WB) || (s == S_BRANCH) || (s == S_JUMP);
  endfunction

endpackage

// File: rtl/mc_ctrl_decode.sv
// Moore output decode: maps the registered FSM state onto the datapath
// control word. Purely combinational, no opcode or handshake inputs.
module mc_ctrl_decode
  import mc_ctrl_pkg::*;
(
  input  logic [STATE_W-1:0] state,
  output ctrl_t              ctrl
);

  always_comb begin
    // NOTE: every output gets a default before the case so no path can leave
    // it unassigned, which would otherwise infer a latch.
    ctrl = CTRL_NONE;
    case (state)
      S_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.ir_write  = 1'b1;
        ctrl.alu_src_a = 1'b0;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.alu_op    = ALU_ADD;
        ctrl.pc_write  = 1'b1;
        ctrl.pc_source = PCSRC_ALU;
      end
      S_DECODE: begin
        // Precompute the branch target into ALUOut while the opcode decodes.
        ctrl.alu_src_a = 1'b0;
        ctrl.alu_src_b = SRCB_IMM_SH2;
        ctrl.alu_op    = ALU_ADD;
      end
      S_MEM_ADDR, S_ADDI_EX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALU_ADD;
      end
      S_MEM_RD: begin
        ctrl.mem_read = 1'b1;
        ctrl.i_or_d   = 1'b1;
      end
      S_MEM_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        ctrl.reg_dst    = 1'b0;
      end
      S_MEM_WR: begin
        ctrl.mem_write = 1'b1;
        ctrl.i_or_d    = 1'b1;
      end
      S_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_REGB;
        ctrl.alu_op    = ALU_FUNCT;
      end
      S_R_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.reg_dst    = 1'b1;
        ctrl.mem_to_reg = 1'b0;
      end
      S_ADDI_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.reg_dst    = 1'b0;
        ctrl.mem_to_reg = 1'b0;
      end
      S_BRANCH: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_src_b     = SRCB_REGB;
        ctrl.alu_op        = ALU_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = PCSRC_ALUOUT;
      end
      S_JUMP: begin
        ctrl.pc_write  = 1'b1;
        ctrl.pc_source = PCSRC_JUMP;
      end
      default: ctrl = CTRL_NONE;
    endcase
  end

endmodule

// File: rtl/mc_control.sv
// Multicycle CPU control FSM with retired-instruction counter.
// Define MEM_HANDSHAKE_EN to stall FETCH/MEM_RD/MEM_WR until mem_ready.
module mc_control
  import mc_ctrl_pkg::*;
#(
  parameter int OP_W  = 6,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [OP_W-1:0]  opcode,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             pc_write_cond,
  output logic             i_or_d,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic             mem_to_reg,
  output logic             reg_dst,
  output logic             reg_write,
  output logic             alu_src_a,
  output logic             illegal_op,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic [1:0]       pc_source,
  output logic [3:0]       state,
  output logic [CNT_W-1:0] instr_count
);

  logic [STATE_W-1:0] state_q;
  logic [STATE_W-1:0] next_state;
  logic [CNT_W-1:0]   count_q;
  logic               mem_done;
  logic               illegal;
  logic               retire;
  ctrl_t              ctrl;

  function automatic logic [OP_W-1:0] op_const(input logic [5:0] c);
    return OP_W'(c);
  endfunction

`ifdef MEM_HANDSHAKE_EN
  assign mem_done = mem_ready;
`else
  assign mem_done = 1'b1;
  // mem_ready is intentionally ignored when the handshake is compiled out.
  logic unused_mem_ready;
  assign unused_mem_ready = mem_ready;
`endif

  // The zero flag is combined with pc_write_cond by the datapath, not here.
  logic unused_zero;
  assign unused_zero = zero;

  always_comb begin
    next_state = S_IDLE;
    illegal    = 1'b0;
    case (state_q)
      S_IDLE:   next_state = S_FETCH;
      S_FETCH:  next_state = mem_done ? S_DECODE : S_FETCH;
      S_DECODE: begin
        if (opcode == op_const(OP_RTYPE)) begin
          next_state = S_EXEC;
        end else if (opcode == op_const(OP_LW) || opcode == op_const(OP_SW)) begin
          next_state = S_MEM_ADDR;
        end else if (opcode == op_const(OP_BEQ)) begin
          next_state = S_BRANCH;
        end else if (opcode == op_const(OP_J)) begin
          next_state = S_JUMP;
        end else if (opcode == op_const(OP_ADDI)) begin
          next_state = S_ADDI_EX;
        end else begin
          illegal    = 1'b1;
          next_state = S_FETCH;
        end
      end
      S_MEM_ADDR: next_state = (opcode == op_const(OP_SW)) ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD:   next_state = mem_done ? S_MEM_WB : S_MEM_RD;
      S_MEM_WR:   next_state = mem_done ? S_FETCH : S_MEM_WR;
      S_EXEC:     next_state = S_R_WB;
      S_ADDI_EX:  next_state = S_ADDI_WB;
      S_MEM_WB, S_R_WB, S_ADDI_WB, S_BRANCH, S_JUMP: next_state = S_FETCH;
      default:    next_state = S_IDLE;
    endcase
  end

  // An illegal opcode exits DECODE to FETCH, so only the six retire states count.
  assign retire = is_retire_state(state_q) && (next_state == S_FETCH);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      count_q <= '0;
    end else begin
      state_q <= next_state;
      if (retire) begin
        count_q <= count_q + CNT_W'(1);
      end
    end
  end

  mc_ctrl_decode u_decode (
    .state (state_q),
    .ctrl  (ctrl)
  );

  // FETCH must not advance the PC until the fetched word is actually present.
  assign pc_write      = ctrl.pc_write & ((state_q != S_FETCH) | mem_done);
  assign pc_write_cond = ctrl.pc_write_cond;
  assign i_or_d        = ctrl.i_or_d;
  assign mem_read      = ctrl.mem_read;
  assign mem_write     = ctrl.mem_write;
  assign ir_write      = ctrl.ir_write;
  assign mem_to_reg    = ctrl.mem_to_reg;
  assign reg_dst       = ctrl.reg_dst;
  assign reg_write     = ctrl.reg_write;
  assign alu_src_a     = ctrl.alu_src_a;
  assign alu_src_b     = ctrl.alu_src_b;
  assign alu_op        = ctrl.alu_op;
  assign pc_source     = ctrl.pc_source;
  assign illegal_op    = illegal;
  assign state         = state_q;
  assign instr_count   = count_q;

endmodule

// File: tb/tb_mc_control.sv
// Directed bench for mc_control: a per-cycle vector table for every
// instruction class, then wrap, mem_ready and asynchronous-reset sequences.
module tb_mc_control;

  localparam int CNT_W = 4;

  logic             clk;
  logic             rst_n;
  logic [5:0]       opcode;
  logic             zero;
  logic             mem_ready;
  logic             pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
  logic             mem_to_reg, reg_dst, reg_write, alu_src_a, illegal_op;
  logic [1:0]       alu_src_b, alu_op, pc_source;
  logic [3:0]       state;
  logic [CNT_W-1:0] instr_count;
  logic [16:0]      ctrl_obs;

  int checks = 0;
  int errors = 0;

  mc_control #(.OP_W(6), .CNT_W(CNT_W)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .opcode        (opcode),
    .zero          (zero),
    .mem_ready     (mem_ready),
    .pc_write      (pc_write),
    .pc_write_cond (pc_write_cond),
    .i_or_d        (i_or_d),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .ir_write      (ir_write),
    .mem_to_reg    (mem_to_reg),
    .reg_dst       (reg_dst),
    .reg_write     (reg_write),
    .alu_src_a     (alu_src_a),
    .illegal_op    (illegal_op),
    .alu_src_b     (alu_src_b),
    .alu_op        (alu_op),
    .pc_source     (pc_source),
    .state         (state),
    .instr_count   (instr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {pw, pwc, iod, mr, mw, irw, m2r, rd, rw, asa, ill, asb[2], aop[2], psrc[2]}
  assign ctrl_obs = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
                     mem_to_reg, reg_dst, reg_write, alu_src_a, illegal_op,
                     alu_src_b, alu_op, pc_source};

  localparam logic [16:0] E_IDLE  = 17'b0_0_0_0_0_0_0_0_0_0_0_00_00_00;
  localparam logic [16:0] E_FETCH = 17'b1_0_0_1_0_1_0_0_0_0_0_01_00_00;
  localparam logic [16:0] E_DEC   = 17'b0_0_0_0_0_0_0_0_0_0_0_11_00_00;
  localparam logic [16:0] E_DECI  = 17'b0_0_0_0_0_0_0_0_0_0_1_11_00_00;
  localparam logic [16:0] E_MADDR = 17'b0_0_0_0_0_0_0_0_0_1_0_10_00_00;
  localparam logic [16:0] E_MRD   = 17'b0_0_1_1_0_0_0_0_0_0_0_00_00_00;
  localparam logic [16:0] E_MWB   = 17'b0_0_0_0_0_0_1_0_1_0_0_00_00_00;
  localparam logic [16:0] E_MWR   = 17'b0_0_1_0_1_0_0_0_0_0_0_00_00_00;
  localparam logic [16:0] E_EXEC  = 17'b0_0_0_0_0_0_0_0_0_1_0_00_10_00;
  localparam logic [16:0] E_RWB   = 17'b0_0_0_0_0_0_0_1_1_0_0_00_00_00;
  localparam logic [16:0] E_BR    = 17'b0_1_0_0_0_0_0_0_0_1_0_00_01_01;
  localparam logic [16:0] E_JMP   = 17'b1_0_0_0_0_0_0_0_0_0_0_00_00_10;
  localparam logic [16:0] E_AWB   = 17'b0_0_0_0_0_0_0_0_1_0_0_00_00_00;

  typedef struct {
    logic [5:0]  op;
    logic        zero;
    logic [3:0]  st;
    logic [16:0] ctrl;
    logic [3:0]  cnt;
  } vec_t;

  localparam int NVEC = 33;
  vec_t vec [NVEC];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Inputs change here, after the sampling point and before the next edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag, input logic [3:0] st, input logic [16:0] c,
                           input logic [3:0] cnt);
    check({tag, " state"}, 32'(state), 32'(st));
    check({tag, " ctrl"}, 32'(ctrl_obs), 32'(c));
    check({tag, " count"}, 32'(instr_count), 32'(cnt));
  endtask

  initial begin
    logic [3:0] exp_cnt;

    // R-type, lw, sw, beq (zero=1 then 0), j, addi, illegal, R-type again.
    vec[0]  = '{6'h00, 1'b0, 4'd1,  E_FETCH, 4'd0};
    vec[1]  = '{6'h00, 1'b0, 4'd2,  E_DEC,   4'd0};
    vec[2]  = '{6'h00, 1'b0, 4'd7,  E_EXEC,  4'd0};
    vec[3]  = '{6'h00, 1'b0, 4'd8,  E_RWB,   4'd0};
    vec[4]  = '{6'h23, 1'b0, 4'd1,  E_FETCH, 4'd1};
    vec[5]  = '{6'h23, 1'b0, 4'd2,  E_DEC,   4'd1};
    vec[6]  = '{6'h23, 1'b0, 4'd3,  E_MADDR, 4'd1};
    vec[7]  = '{6'h23, 1'b0, 4'd4,  E_MRD,   4'd1};
    vec[8]  = '{6'h23, 1'b0, 4'd5,  E_MWB,   4'd1};
    vec[9]  = '{6'h2B, 1'b0, 4'd1,  E_FETCH, 4'd2};
    vec[10] = '{6'h2B, 1'b0, 4'd2,  E_DEC,   4'd2};
    vec[11] = '{6'h2B, 1'b0, 4'd3,  E_MADDR, 4'd2};
    vec[12] = '{6'h2B, 1'b0, 4'd6,  E_MWR,   4'd2};
    vec[13] = '{6'h04, 1'b1, 4'd1,  E_FETCH, 4'd3};
    vec[14] = '{6'h04, 1'b1, 4'd2,  E_DEC,   4'd3};
    vec[15] = '{6'h04, 1'b1, 4'd9,  E_BR,    4'd3};
    vec[16] = '{6'h04, 1'b0, 4'd1,  E_FETCH, 4'd4};
    vec[17] = '{6'h04, 1'b0, 4'd2,  E_DEC,   4'd4};
    vec[18] = '{6'h04, 1'b0, 4'd9,  E_BR,    4'd4};
    vec[19] = '{6'h02, 1'b0, 4'd1,  E_FETCH, 4'd5};
    vec[20] = '{6'h02, 1'b0, 4'd2,  E_DEC,   4'd5};
    vec[21] = '{6'h02, 1'b0, 4'd10, E_JMP,   4'd5};
    vec[22] = '{6'h08, 1'b0, 4'd1,  E_FETCH, 4'd6};
    vec[23] = '{6'h08, 1'b0, 4'd2,  E_DEC,   4'd6};
    vec[24] = '{6'h08, 1'b0, 4'd11, E_MADDR, 4'd6};
    vec[25] = '{6'h08, 1'b0, 4'd12, E_AWB,   4'd6};
    vec[26] = '{6'h3F, 1'b0, 4'd1,  E_FETCH, 4'd7};
    vec[27] = '{6'h3F, 1'b0, 4'd2,  E_DECI,  4'd7};
    vec[28] = '{6'h3F, 1'b0, 4'd1,  E_FETCH, 4'd7};
    vec[29] = '{6'h00, 1'b0, 4'd2,  E_DEC,   4'd7};
    vec[30] = '{6'h00, 1'b0, 4'd7,  E_EXEC,  4'd7};
    vec[31] = '{6'h00, 1'b0, 4'd8,  E_RWB,   4'd7};
    vec[32] = '{6'h00, 1'b0, 4'd1,  E_FETCH, 4'd8};

    rst_n     = 1'b0;
    opcode    = 6'h00;
    zero      = 1'b0;
    mem_ready = 1'b1;
    repeat (2) step();
    check_all("reset", 4'd0, E_IDLE, 4'd0);
    rst_n = 1'b1;

    for (int i = 0; i < NVEC; i++) begin
      opcode = vec[i].op;
      zero   = vec[i].zero;
      step();
      check_all($sformatf("vec%0d", i), vec[i].st, vec[i].ctrl, vec[i].cnt);
    end

    // Eight jumps take the 4-bit counter from 8 around to 0.
    exp_cnt = 4'd8;
    opcode  = 6'h02;
    for (int i = 0; i < 8; i++) begin
      repeat (3) step();
      exp_cnt = exp_cnt + 4'd1;
      check($sformatf("wrap%0d state", i), 32'(state), 32'd1);
      check($sformatf("wrap%0d count", i), 32'(instr_count), 32'(exp_cnt));
    end
    check("wrap final", 32'(instr_count), 32'd0);

`ifdef MEM_HANDSHAKE_EN
    mem_ready = 1'b0;
    #1;
    check("hs pc_write low", 32'(pc_write), 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("hs hold%0d state", i), 32'(state), 32'd1);
      check($sformatf("hs hold%0d pc_write", i), 32'(pc_write), 32'd0);
      check($sformatf("hs hold%0d mem_read", i), 32'(mem_read), 32'd1);
    end
    mem_ready = 1'b1;
    #1;
    check("hs pc_write ready", 32'(pc_write), 32'd1);
    step();
    check("hs release state", 32'(state), 32'd2);
`else
    mem_ready = 1'b0;
    step();
    check("no-hs fetch one cycle", 32'(state), 32'd2);
    mem_ready = 1'b1;
`endif

    step();
    check("jump after ready", 32'(state), 32'd10);
    step();
    check_all("jump retire", 4'd1, E_FETCH, 4'd1);

    // Store interrupted by reset while in MEM_WR.
    opcode = 6'h2B;
    repeat (3) step();
    check("sw in MEM_WR", 32'(state), 32'd6);
    check("sw mem_write", 32'(mem_write), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_all("async reset", 4'd0, E_IDLE, 4'd0);
    #1;
    rst_n = 1'b1;
    step();
    check_all("post reset", 4'd1, E_FETCH, 4'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
